// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_carry_reg.sv
// Single-bit carry flop with load-enable; closes the full-adder carry loop between serial steps.
// Latency: one cycle from d to q when en is high. Holds q while en is low.
module serial_adder_carry_reg (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_SUBTRACT_EN adds a sub port for a - b.
// Latency: done pulses WIDTH+1 cycles after an accepted start; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy or done are dropped.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, b_load, sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry_q, carry_d, carry_en, carry_init;
    logic             load, shift, last;
    logic             s_bit, c_bit;

`ifdef SERIAL_ADDER_SUBTRACT_EN
    // Subtraction as a + ~b + 1: invert B on load and seed the carry with 1.
    assign b_load     = sub ? ~b : b;
    assign carry_init = sub;
`else
    assign b_load     = b;
    assign carry_init = 1'b0;
`endif

    assign s_bit = a_sr[0] ^ b_sr[0] ^ carry_q;
    assign c_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
    assign last  = (cnt == CW'(WIDTH - 1));

    always_comb begin
        sum_sh            = sum >> 1;
        sum_sh[WIDTH-1]   = s_bit;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign carry_en = load | shift;
    assign carry_d  = load ? carry_init : c_bit;

    serial_adder_carry_reg u_carry (
        .clk (clk),
        .rst (rst),
        .en  (carry_en),
        .d   (carry_d),
        .q   (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
            if (load) begin
                a_sr <= a;
                b_sr <= b_load;
                cnt  <= '0;
                sum  <= '0;
            end else if (shift) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                cnt  <= cnt + CW'(1);
                sum  <= sum_sh;
                // cout only moves on the final step so it is never seen partial.
                if (last) begin
                    cout <= c_bit;
                end
            end
        end
    end

endmodule
